// File: rtl/piece_slide_animator.sv
// piece_slide_animator: slides a sprite square-to-square, one step per frame_tick
// Ports: vga_clk/reset (async, active-high); frame_tick (vblank pulse);
//   start + from/to col/row + capture_en (move request, taken when ready);
//   ready/busy (idle flag and its complement); offsetX/offsetY (unscaled sprite origin);
//   captured (sticky victim-hide flag); done (one-cycle completion pulse).
module piece_slide_animator #(
  parameter int SQ_SIZE = 60,
  parameter int STEP_PX = 4
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [2:0] from_col,
  input  logic [2:0] from_row,
  input  logic [2:0] to_col,
  input  logic [2:0] to_row,
  input  logic       capture_en,
  output logic       ready,
  output logic       busy,
  output logic [9:0] offsetX,
  output logic [9:0] offsetY,
  output logic       captured,
  output logic       done
);
  localparam logic [9:0] SQ   = 10'(SQ_SIZE);
  localparam logic [9:0] STEP = 10'(STEP_PX);
  typedef enum logic [1:0] {IDLE, MOVE, SETTLE} state_t;
  state_t     state, state_n;
  logic [9:0] tgt_x, tgt_y, tgt_x_n, tgt_y_n, off_x_n, off_y_n;
  logic       cap_en, cap_en_n, captured_n, done_n;
  // Direction comes from the unsigned compare; the step is clamped to the gap so it never overshoots.
  function automatic logic [9:0] step_to(input logic [9:0] cur, input logic [9:0] tgt);
    logic [9:0] gap;
    gap = (tgt > cur) ? tgt - cur : cur - tgt;
    gap = (gap > STEP) ? STEP : gap;
    return (tgt > cur) ? cur + gap : cur - gap;
  endfunction
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      offsetX  <= '0;
      offsetY  <= '0;
      tgt_x    <= '0;
      tgt_y    <= '0;
      cap_en   <= 1'b0;
      captured <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      offsetX  <= off_x_n;
      offsetY  <= off_y_n;
      tgt_x    <= tgt_x_n;
      tgt_y    <= tgt_y_n;
      cap_en   <= cap_en_n;
      captured <= captured_n;
      done     <= done_n;
    end
  end
  always_comb begin
    state_n    = state;
    off_x_n    = offsetX;
    off_y_n    = offsetY;
    tgt_x_n    = tgt_x;
    tgt_y_n    = tgt_y;
    cap_en_n   = cap_en;
    captured_n = captured;
    done_n     = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n    = MOVE;
        off_x_n    = 10'(from_col) * SQ;
        off_y_n    = 10'(from_row) * SQ;
        tgt_x_n    = 10'(to_col) * SQ;
        tgt_y_n    = 10'(to_row) * SQ;
        cap_en_n   = capture_en;
        captured_n = 1'b0;
      end
      // Arrival is only recognised on a tick, so the final position shows for a full frame before captured rises.
      MOVE: if (frame_tick) begin
        if (offsetX == tgt_x && offsetY == tgt_y) begin
          state_n    = SETTLE;
          captured_n = cap_en;
        end else begin
          off_x_n = step_to(offsetX, tgt_x);
          off_y_n = step_to(offsetY, tgt_y);
        end
      end
      SETTLE: if (frame_tick) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  assign ready = (state == IDLE);
  assign busy  = ~ready;
endmodule

// File: tb/tb_piece_slide_animator.sv
// tb_piece_slide_animator: random and directed moves on STEP_PX=4 and STEP_PX=7 instances against a closed-form model
module tb_piece_slide_animator;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       capture_en = 1'b0;
  logic [2:0] from_col = '0, from_row = '0, to_col = '0, to_row = '0;
  logic [9:0] ox [2];
  logic [9:0] oy [2];
  logic       cp [2];
  logic       dn [2];
  logic       rd [2];
  logic       bs [2];
  int         steps [2] = '{4, 7};
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  piece_slide_animator #(.SQ_SIZE(60), .STEP_PX(4)) u4 (
    .vga_clk(clk), .reset(rst), .frame_tick(frame_tick), .start(start),
    .from_col(from_col), .from_row(from_row), .to_col(to_col), .to_row(to_row),
    .capture_en(capture_en), .ready(rd[0]), .busy(bs[0]), .offsetX(ox[0]),
    .offsetY(oy[0]), .captured(cp[0]), .done(dn[0])
  );
  piece_slide_animator #(.SQ_SIZE(60), .STEP_PX(7)) u7 (
    .vga_clk(clk), .reset(rst), .frame_tick(frame_tick), .start(start),
    .from_col(from_col), .from_row(from_row), .to_col(to_col), .to_row(to_row),
    .capture_en(capture_en), .ready(rd[1]), .busy(bs[1]), .offsetX(ox[1]),
    .offsetY(oy[1]), .captured(cp[1]), .done(dn[1])
  );

  function automatic int iabs(int v);
    return v < 0 ? -v : v;
  endfunction

  // Position after k ticks: travel k*step toward the target, capped at the distance.
  function automatic int exp_pos(int f, int t, int k, int s);
    int d = t - f;
    int m = k * s;
    if (d >= 0) return f + (m < d ? m : d);
    return f - (m < -d ? m : -d);
  endfunction

  function automatic int ticks_needed(int dx, int dy, int s);
    int mx = iabs(dx) > iabs(dy) ? iabs(dx) : iabs(dy);
    return (mx + s - 1) / s;
  endfunction

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic do_move(input int fc, input int fr, input int tc, input int tr, input bit cap,
                         input bit with_tick, input bit second_start);
    int n [2];
    int last, ex, ey;
    logic [23:0] got, want;
    @(negedge clk);
    from_col = 3'(fc); from_row = 3'(fr); to_col = 3'(tc); to_row = 3'(tr);
    capture_en = cap; start = 1'b1; frame_tick = with_tick;
    @(negedge clk);
    start = 1'b0; frame_tick = 1'b0;
    last = 0;
    for (int i = 0; i < 2; i++) begin
      n[i] = ticks_needed((tc - fc) * 60, (tr - fr) * 60, steps[i]);
      if (n[i] + 3 > last) last = n[i] + 3;
      got  = {ox[i], oy[i], cp[i], dn[i], rd[i], bs[i]};
      want = {10'(fc * 60), 10'(fr * 60), 4'b0001};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL accept dut%0d (%0d,%0d)->(%0d,%0d): got %h want %h", i, fc, fr, tc, tr, got, want);
      end
    end
    for (int k = 1; k <= last; k++) begin
      if (second_start && k == 3) begin
        @(negedge clk);
        from_col = 3'($urandom_range(7)); from_row = 3'($urandom_range(7));
        to_col = 3'($urandom_range(7)); to_row = 3'($urandom_range(7));
        capture_en = ~cap; start = 1'b1;
        @(negedge clk) start = 1'b0;
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        ex = exp_pos(fc * 60, tc * 60, k, steps[i]);
        ey = exp_pos(fr * 60, tr * 60, k, steps[i]);
        got  = {ox[i], oy[i], cp[i], dn[i], rd[i], bs[i]};
        want = {10'(ex), 10'(ey), (k >= n[i] + 1) ? cap : 1'b0, k == n[i] + 2,
                k >= n[i] + 2, k < n[i] + 2};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL tick dut%0d (%0d,%0d)->(%0d,%0d) k=%0d: got %h want %h", i, fc, fr, tc, tr, k, got, want);
        end
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        ex = exp_pos(fc * 60, tc * 60, k, steps[i]);
        checks++;
        if (dn[i] !== 1'b0 || ox[i] !== 10'(ex)) begin
          errors++;
          $display("FAIL between_ticks dut%0d k=%0d: done=%b x=%0d want done=0 x=%0d", i, k, dn[i], ox[i], ex);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({ox[i], oy[i], cp[i], dn[i], rd[i], bs[i]} !== 24'h000002) begin
        errors++;
        $display("FAIL reset dut%0d: got %h want 000002", i, {ox[i], oy[i], cp[i], dn[i], rd[i], bs[i]});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_move();
    @(negedge clk);
    from_col = 0; from_row = 0; to_col = 7; to_row = 7; capture_en = 1'b1; start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5) tick();
    @(negedge clk) rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({ox[i], oy[i], cp[i], dn[i], rd[i], bs[i]} !== 24'h000002) begin
        errors++;
        $display("FAIL reset_mid_move dut%0d: got %h want 000002", i, {ox[i], oy[i], cp[i], dn[i], rd[i], bs[i]});
      end
    end
    @(negedge clk) rst = 1'b0;
    repeat (4) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dn[i] !== 1'b0 || rd[i] !== 1'b1 || ox[i] !== 10'd0) begin
          errors++;
          $display("FAIL post_reset_idle dut%0d: done=%b ready=%b x=%0d want 0 1 0", i, dn[i], rd[i], ox[i]);
        end
      end
    end
    do_move(1, 2, 3, 2, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_horizontal();
    do_move(0, 6, 1, 6, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_diagonal_capture();
    do_move(2, 7, 5, 4, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    checks++;
    if (cp[0] !== 1'b1 || cp[1] !== 1'b1) begin
      errors++;
      $display("FAIL captured_sticky: got %b%b want 11", cp[0], cp[1]);
    end
  endtask

  task automatic test_non_multiple();
    do_move(0, 0, 0, 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_collisions();
    do_move(3, 3, 3, 3, 1'b1, 1'b0, 1'b0);
    do_move(6, 1, 2, 5, 1'b0, 1'b1, 1'b0);
    do_move(7, 0, 0, 7, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    int fc, fr, tc, tr, mn;
    for (int r = 0; r < 8; r++) begin
      fc = $urandom_range(7); fr = $urandom_range(7);
      tc = $urandom_range(7); tr = $urandom_range(7);
      mn = ticks_needed((tc - fc) * 60, (tr - fr) * 60, 7);
      do_move(fc, fr, tc, tr, 1'($urandom_range(1)), 1'($urandom_range(1)),
              mn >= 3 ? 1'($urandom_range(1)) : 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_diagonal_capture();
    test_non_multiple();
    test_collisions();
    test_reset_mid_move();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
